// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_arb_pkg                                           |
// | Purpose  : Shared types and defaults for the two-requester       |
// |            memory-port arbiter (mem_arbiter).                    |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package mem_arb_pkg;

    // Ownership state of the shared memory port
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    // Identity of the requester that most recently took the port
    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    // Default burst limit before the waiting requester is given the port
    localparam int c_MAX_HOLD_DEFAULT = 8;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_arbiter                                           |
// | Purpose  : Arbitrates one synchronous memory port between a      |
// |            cache (A) and a UART controller (B) with a bounded    |
// |            burst length and zero-dead-cycle grant hand-over.     |
// | Options  : ARB_ROUND_ROBIN_EN - idle ties go to the requester    |
// |            that did not own the port last (default: A wins).     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = c_MAX_HOLD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_gnt,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_rvalid,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_di,
    input  logic [DATA_WIDTH-1:0] mem_do
);

    localparam logic [7:0] c_HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     r_state;
    logic [7:0] r_hold;
    logic       r_a_rvalid;
    logic       r_b_rvalid;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t     r_last_owner;
`endif

    state_t     w_next_state;
    state_t     w_tie_state;
    logic       w_a_acc;
    logic       w_b_acc;
    logic [7:0] w_hold_inc;

    // Grants come straight from the registered state
    assign a_gnt   = (r_state == OWN_A);
    assign b_gnt   = (r_state == OWN_B);

    // An access happens only while the owner keeps requesting
    assign w_a_acc = a_req && a_gnt;
    assign w_b_acc = b_req && b_gnt;

    // Owner's request is passed through to the memory in the same cycle
    assign mem_en   = w_a_acc || w_b_acc;
    assign mem_we   = (w_a_acc && a_we) || (w_b_acc && b_we);
    assign mem_addr = b_gnt ? b_addr  : a_addr;
    assign mem_di   = b_gnt ? b_wdata : a_wdata;

    // Read data is broadcast; rvalid tells each requester whether it is theirs
    assign a_rdata  = mem_do;
    assign b_rdata  = mem_do;
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;

    // Hold count saturates so a lone requester can stream indefinitely
    assign w_hold_inc = (r_hold >= c_HOLD_LIMIT) ? c_HOLD_LIMIT : (r_hold + 8'd1);

`ifdef ARB_ROUND_ROBIN_EN
    assign w_tie_state = (r_last_owner == OWNER_A) ? OWN_B : OWN_A;
`else
    assign w_tie_state = OWN_A;
`endif

    // Next owner: idle pick, release on dropped request, rotate at burst limit
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (a_req && b_req)  w_next_state = w_tie_state;
                else if (a_req)      w_next_state = OWN_A;
                else if (b_req)      w_next_state = OWN_B;
            end
            OWN_A: begin
                if (!a_req)          w_next_state = b_req ? OWN_B : IDLE;
                else if (b_req && (w_hold_inc == c_HOLD_LIMIT))
                                     w_next_state = OWN_B;
            end
            OWN_B: begin
                if (!b_req)          w_next_state = a_req ? OWN_A : IDLE;
                else if (a_req && (w_hold_inc == c_HOLD_LIMIT))
                                     w_next_state = OWN_A;
            end
            default:                 w_next_state = IDLE;
        endcase
    end

    // State, burst counter and read-valid pulses; reset drops everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hold       <= 8'd0;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= OWNER_B;
`endif
        end else begin
            r_a_rvalid <= w_a_acc && !a_we;
            r_b_rvalid <= w_b_acc && !b_we;
            r_state    <= w_next_state;
            if (w_next_state != r_state) begin
                r_hold <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
                if (w_next_state == OWN_A)      r_last_owner <= OWNER_A;
                else if (w_next_state == OWN_B) r_last_owner <= OWNER_B;
`endif
            end else if (mem_en) begin
                r_hold <= w_hold_inc;
            end
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                        |
// | Purpose  : Self-checking bench for mem_arbiter: directed         |
// |            scenarios plus randomized traffic against a           |
// |            behavioural ownership/memory model.                   |
// | Options  : ARB_ROUND_ROBIN_EN changes the expected tie winner.   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, accesses in this tenure, last owner
    int            m_owner;   // 0 none, 1 A, 2 B
    int            m_burst;
    int            m_last;
    bit            m_rva, m_rvb;
    logic [DW-1:0] m_data;
    logic [DW-1:0] ref_mem [256];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_di(mem_di), .mem_do(mem_do)
    );

    always #5 clk = ~clk;

    // Synchronous memory with one-cycle read latency, driven by the DUT port
    initial begin : p_memory
        logic [DW-1:0] mem [256];
        for (int i = 0; i < 256; i++) mem[i] = (32'(i) * 32'h01010101) ^ 32'hC0DE0000;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) mem[mem_addr[7:0]] <= mem_di;
                else        mem_do <= mem[mem_addr[7:0]];
            end
        end
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_owner = 0; m_burst = 0; m_last = 2; m_rva = 0; m_rvb = 0;
    endtask

    task automatic model_enter(input int who);
        m_owner = who; m_burst = 0; m_last = who;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit acc_a, acc_b, own_req, oth_req;
        acc_a = (m_owner == 1) && a_req;
        acc_b = (m_owner == 2) && b_req;
        m_rva = acc_a && !a_we;
        m_rvb = acc_b && !b_we;
        if (acc_a) begin
            if (a_we) ref_mem[a_addr[7:0]] = a_wdata; else m_data = ref_mem[a_addr[7:0]];
        end
        if (acc_b) begin
            if (b_we) ref_mem[b_addr[7:0]] = b_wdata; else m_data = ref_mem[b_addr[7:0]];
        end
        if (m_owner == 0) begin
            if (a_req && b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                model_enter((m_last == 1) ? 2 : 1);
`else
                model_enter(1);
`endif
            end else if (a_req) model_enter(1);
            else if (b_req)     model_enter(2);
        end else begin
            own_req = (m_owner == 1) ? a_req : b_req;
            oth_req = (m_owner == 1) ? b_req : a_req;
            if (!own_req) begin
                if (oth_req) model_enter(3 - m_owner);
                else begin m_owner = 0; m_burst = 0; end
            end else begin
                m_burst = (m_burst + 1 > MAX_HOLD) ? MAX_HOLD : m_burst + 1;
                if (m_burst == MAX_HOLD && oth_req) model_enter(3 - m_owner);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (a_gnt !== 1'b0)    begin errors++; $display("FAIL reset_a_gnt got %b exp 0", a_gnt); end
        checks++; if (b_gnt !== 1'b0)    begin errors++; $display("FAIL reset_b_gnt got %b exp 0", b_gnt); end
        checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_a_rvalid got %b exp 0", a_rvalid); end
        checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_b_rvalid got %b exp 0", b_rvalid); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem got en=%b we=%b exp 0/0", mem_en, mem_we); end
        step();
    endtask

    task automatic test_single_a();
        logic [DW-1:0] exp_d;
        do_reset();
        a_req = 1; a_we = 0; a_addr = 16'h0010;
        exp_d = ref_mem[8'h10];
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (a_gnt !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL single_gnt c%0d got %b exp %b", k, a_gnt, (k >= 1 && k <= 4)); end
            checks++; if (mem_en !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL single_en c%0d got %b exp %b", k, mem_en, (k >= 1 && k <= 3)); end
            if (k >= 1 && k <= 3) begin
                checks++; if (mem_we !== 1'b0 || mem_addr !== 16'h0010) begin errors++; $display("FAIL single_req c%0d got we=%b addr=%h exp 0/0010", k, mem_we, mem_addr); end
            end
            checks++; if (a_rvalid !== (k >= 2 && k <= 4)) begin errors++; $display("FAIL single_rvalid c%0d got %b exp %b", k, a_rvalid, (k >= 2 && k <= 4)); end
            if (k >= 2 && k <= 4) begin
                checks++; if (a_rdata !== exp_d) begin errors++; $display("FAIL single_rdata c%0d got %h exp %h", k, a_rdata, exp_d); end
            end
            checks++; if (b_rvalid !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL single_b c%0d got gnt=%b rv=%b exp 0/0", k, b_gnt, b_rvalid); end
            step();
            if (k == 3) a_req = 0;
        end
    endtask

    task automatic test_tie();
        do_reset();
        a_req = 1; b_req = 1; a_we = 0; b_we = 0;
        @(negedge clk);
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL tie_idle got a=%b b=%b exp 0/0", a_gnt, b_gnt); end
        step();
        @(negedge clk);
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL tie_first got a=%b b=%b exp 1/0", a_gnt, b_gnt); end
        step();
        a_req = 0; b_req = 0;
        step();
        @(negedge clk);
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL tie_release got a=%b b=%b exp 0/0", a_gnt, b_gnt); end
        a_req = 1; b_req = 1;
        step();
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b1) begin errors++; $display("FAIL tie_second got a=%b b=%b exp 0/1", a_gnt, b_gnt); end
`else
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL tie_second got a=%b b=%b exp 1/0", a_gnt, b_gnt); end
`endif
        a_req = 0; b_req = 0;
        step(); step();
    endtask

    // Continuous contention: A reads, B writes, bursts of MAX_HOLD alternate
    task automatic test_back_to_back();
        bit            exp_a, exp_rv;
        logic [DW-1:0] exp_d;
        do_reset();
        a_req = 1; a_we = 0; a_addr = 16'h0130;
        b_req = 1; b_we = 1; b_addr = 16'h0240; b_wdata = 32'h5A5A1234;
        exp_d = ref_mem[8'h30];
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL b2b_idle got a=%b b=%b exp 0/0", a_gnt, b_gnt); end
            end else begin
                exp_a = (((k - 1) / MAX_HOLD) % 2) == 0;
                checks++; if (a_gnt !== exp_a || b_gnt !== !exp_a) begin errors++; $display("FAIL b2b_gnt c%0d got a=%b b=%b exp %b/%b", k, a_gnt, b_gnt, exp_a, !exp_a); end
                checks++; if (mem_en !== 1'b1 || mem_we !== !exp_a) begin errors++; $display("FAIL b2b_mem c%0d got en=%b we=%b exp 1/%b", k, mem_en, mem_we, !exp_a); end
                checks++; if (mem_addr !== (exp_a ? 16'h0130 : 16'h0240)) begin errors++; $display("FAIL b2b_addr c%0d got %h", k, mem_addr); end
            end
            exp_rv = (k >= 2) && ((((k - 2) / MAX_HOLD) % 2) == 0);
            checks++; if (a_rvalid !== exp_rv) begin errors++; $display("FAIL b2b_a_rvalid c%0d got %b exp %b", k, a_rvalid, exp_rv); end
            if (exp_rv) begin
                checks++; if (a_rdata !== exp_d) begin errors++; $display("FAIL b2b_rdata c%0d got %h exp %h", k, a_rdata, exp_d); end
            end
            checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_b_rvalid c%0d got %b exp 0", k, b_rvalid); end
            step();
        end
        a_req = 0; b_req = 0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        a_req = 1; a_we = 0; a_addr = 16'h0020;
        step(); step();
        @(negedge clk);
        checks++; if (a_rvalid !== 1'b1 || a_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_pre got gnt=%b rv=%b exp 1/1", a_gnt, a_rvalid); end
        #1 rst = 1'b1; a_req = 0;
        model_reset();
        #1;
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_gnt got a=%b b=%b exp 0/0", a_gnt, b_gnt); end
        checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got a=%b b=%b exp 0/0", a_rvalid, b_rvalid); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b exp 0", mem_en); end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_gnt !== 1'b0) begin errors++; $display("FAIL rstmid_after c%0d got rv=%b/%b gnt=%b exp 0", k, a_rvalid, b_rvalid, a_gnt); end
            step();
        end
    endtask

    task automatic test_random();
        bit            e_a, e_b, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_di;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            a_req   = ($urandom_range(0, 3) != 0);
            b_req   = ($urandom_range(0, 2) != 0);
            a_we    = $urandom_range(0, 1) == 1;
            b_we    = $urandom_range(0, 1) == 1;
            a_addr  = AW'($urandom);
            b_addr  = AW'($urandom);
            a_wdata = $urandom;
            b_wdata = $urandom;
            @(negedge clk);
            e_a    = (m_owner == 1);
            e_b    = (m_owner == 2);
            e_en   = (e_a && a_req) || (e_b && b_req);
            e_we   = e_en && (e_a ? a_we : b_we);
            e_addr = e_b ? b_addr : a_addr;
            e_di   = e_b ? b_wdata : a_wdata;
            checks++; if (a_gnt !== e_a || b_gnt !== e_b) begin errors++; $display("FAIL rnd_gnt n%0d got a=%b b=%b exp %b/%b", n, a_gnt, b_gnt, e_a, e_b); end
            checks++; if (mem_en !== e_en || mem_we !== e_we) begin errors++; $display("FAIL rnd_mem n%0d got en=%b we=%b exp %b/%b", n, mem_en, mem_we, e_en, e_we); end
            if (e_en) begin
                checks++; if (mem_addr !== e_addr || (e_we && mem_di !== e_di)) begin errors++; $display("FAIL rnd_bus n%0d got %h/%h exp %h/%h", n, mem_addr, mem_di, e_addr, e_di); end
            end
            checks++; if (a_rvalid !== m_rva || b_rvalid !== m_rvb) begin errors++; $display("FAIL rnd_rvalid n%0d got %b/%b exp %b/%b", n, a_rvalid, b_rvalid, m_rva, m_rvb); end
            if (m_rva || m_rvb) begin
                checks++; if ((m_rva ? a_rdata : b_rdata) !== m_data) begin errors++; $display("FAIL rnd_rdata n%0d got %h exp %h", n, (m_rva ? a_rdata : b_rdata), m_data); end
            end
            step();
        end
        a_req = 0; b_req = 0;
        step();
    endtask

    initial begin : p_main
        for (int i = 0; i < 256; i++) ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'hC0DE0000;
        m_data = '0;
        model_reset();
        test_reset();
        test_single_a();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
